// File: rtl/serial_addsub_ctrl.sv
// Bit-serial add/subtract sequencer: operands are fed LSB-first through one shared
// full-adder cell, with the inter-bit carry held in a flop between clocks.

module serial_addsub_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// Handshake: i_start is sampled only while idle (o_busy=0); once accepted, o_busy stays
// high until the cycle after the single-cycle o_done pulse, and starts seen meanwhile are dropped.
module serial_addsub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic [1:0]       o_state
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sh_a;
    logic [WIDTH-1:0] r_sh_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_carry_out;
    logic             r_overflow;

    logic             w_sum;
    logic             w_cout;

    serial_addsub_fa u_fa (
        .i_a (r_sh_a[0]),
        .i_b (r_sh_b[0]),
        .i_c (r_carry),
        .o_s (w_sum),
        .o_c (w_cout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        // Subtraction is A + ~B + 1: invert B here and seed the carry with 1.
                        r_sh_a  <= i_a;
                        r_sh_b  <= i_b ^ {WIDTH{i_mode}};
                        r_carry <= i_mode;
                        r_cnt   <= '0;
                        r_res   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res   <= {w_sum, r_res[WIDTH-1:1]};
                    r_sh_a  <= r_sh_a >> 1;
                    r_sh_b  <= r_sh_b >> 1;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        // r_carry still holds the carry into the MSB on this edge.
                        r_result    <= {w_sum, r_res[WIDTH-1:1]};
                        r_carry_out <= w_cout;
                        r_overflow  <= r_carry ^ w_cout;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy     = (r_state != S_IDLE);
    assign o_done     = (r_state == S_DONE);
    assign o_result   = r_result;
    assign o_carry    = r_carry_out;
    assign o_overflow = r_overflow;
    assign o_state    = r_state;
endmodule
